// File: rtl/snake_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake-game blocks: default RAM geometry,
// channel-B requester indices, movement direction encodings and the
// read-tag record carried through the RAM read pipeline.
// No ports (package).
// ----------------------------------------------------------------------------
package snake_pkg;

    localparam int unsigned SNAKE_ADDR_W = 11;
    localparam int unsigned SNAKE_DATA_W = 8;

    // Channel-B requester indices
    localparam logic REQ_DISP = 1'b0;
    localparam logic REQ_GAME = 1'b1;

    // Movement direction encodings shared by all snake blocks
    typedef enum logic [1:0] {
        FORWARD_X_UP   = 2'b00,
        FORWARD_X_DOWN = 2'b01,
        FORWARD_Y_UP   = 2'b10,
        FORWARD_Y_DOWN = 2'b11
    } forward_e;

    // One in-flight channel-B access: valid marks a read, owner its requester
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/snake_dpb_b_arbiter_if.sv
// ----------------------------------------------------------------------------
// snake_dpb_b_arbiter_if
// Bundles the two requester handshakes and the channel-B RAM pins of the
// snake dual-port block RAM arbiter.
//   req0/req1, addr0/addr1, we0/we1, wdata0/wdata1 : requester commands
//   gnt0/gnt1                                      : accept pulses
//   rvalid0/rvalid1, rdata0/rdata1                 : read returns
//   b_clk_en, b_data_en, b_wr_en, b_address, b_data: RAM command pins
//   b_q                                            : RAM read data
// Modports: slave = arbiter side, master = requesters + RAM side.
// ----------------------------------------------------------------------------
interface snake_dpb_b_arbiter_if
    import snake_pkg::*;
#(
    parameter int unsigned ADDR_W = SNAKE_ADDR_W,
    parameter int unsigned DATA_W = SNAKE_DATA_W
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              b_clk_en;
    logic              b_data_en;
    logic              b_wr_en;
    logic [ADDR_W-1:0] b_address;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] b_q;

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, b_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               b_clk_en, b_data_en, b_wr_en, b_address, b_data
    );

    modport master (
        output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, b_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               b_clk_en, b_data_en, b_wr_en, b_address, b_data
    );

endinterface

// File: rtl/snake_rd_tag_pipe.sv
// ----------------------------------------------------------------------------
// snake_rd_tag_pipe
// Shift register of {valid, owner} tags that tracks channel-B accesses
// through the RAM read latency.
//   clk   : clock
//   clr_i : synchronous clear, drops every in-flight tag
//   tag_i : tag for the command registered this cycle
//   tag_o : tag of the access whose data is on b_q this cycle
// ----------------------------------------------------------------------------
module snake_rd_tag_pipe
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    clk,
    input  logic    clr_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/snake_dpb_b_arbiter.sv
// ----------------------------------------------------------------------------
// snake_dpb_b_arbiter
// Round-robin arbiter sharing channel B of the snake dual-port block RAM
// between the display scanner (requester 0) and the game logic
// (requester 1). Issues one registered RAM command per cycle and returns
// each read to its owner with a registered valid strobe.
//   clk : clock shared with the RAM
//   rst : synchronous active-high reset
//   bus : requester handshakes and channel-B RAM pins (slave modport)
// ----------------------------------------------------------------------------
module snake_dpb_b_arbiter
    import snake_pkg::*;
#(
    parameter int unsigned ADDR_W = SNAKE_ADDR_W,
    parameter int unsigned DATA_W = SNAKE_DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    snake_dpb_b_arbiter_if.slave  bus
);

    logic              gnt0;
    logic              gnt1;

    logic              last_q,    last_d;
    logic              ce_q,      ce_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              data_en_q;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,  rdata0_d;
    logic [DATA_W-1:0] rdata1_q,  rdata1_d;

    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    // Grants are suppressed while in reset so a held request is accepted
    // in the first cycle after rst falls.
    always_comb begin
        gnt0 = ~rst & bus.req0 & (~bus.req1 | (last_q != REQ_DISP));
        gnt1 = ~rst & bus.req1 & (~bus.req0 | (last_q != REQ_GAME));
    end

    always_comb begin
        last_d = last_q;
        ce_d   = 1'b0;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        tag_in = '0;
        if (gnt0) begin
            last_d       = REQ_DISP;
            ce_d         = 1'b1;
            we_d         = bus.we0;
            addr_d       = bus.addr0;
            data_d       = bus.wdata0;
            tag_in.valid = ~bus.we0;
            tag_in.owner = REQ_DISP;
        end else if (gnt1) begin
            last_d       = REQ_GAME;
            ce_d         = 1'b1;
            we_d         = bus.we1;
            addr_d       = bus.addr1;
            data_d       = bus.wdata1;
            tag_in.valid = ~bus.we1;
            tag_in.owner = REQ_GAME;
        end
    end

    // The tag leaves the pipe in the same cycle its data sits on b_q.
    snake_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .clr_i (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (tag_out.valid) begin
            if (tag_out.owner == REQ_DISP) begin
                rvalid0_d = 1'b1;
                rdata0_d  = bus.b_q;
            end else begin
                rvalid1_d = 1'b1;
                rdata1_d  = bus.b_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= REQ_GAME;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            data_en_q <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            data_en_q <= 1'b1;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.b_clk_en  = ce_q;
    assign bus.b_data_en = data_en_q;
    assign bus.b_wr_en   = we_q;
    assign bus.b_address = addr_q;
    assign bus.b_data    = data_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_snake_dpb_b_arbiter.sv
// ----------------------------------------------------------------------------
// tb_snake_dpb_b_arbiter
// Scoreboard bench for snake_dpb_b_arbiter. Two instances share clk/rst:
// side 0 built with RD_LAT=2, side 1 with RD_LAT=1, each with its own
// write-first RAM model. Stimulus pushes expected grants, RAM commands and
// read returns; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_snake_dpb_b_arbiter;
    import snake_pkg::*;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    typedef struct {
        int          cyc;
        logic        owner;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle  = 0;
    int   errors = 0;
    int   checks = 0;
    int   lat [2] = '{2, 1};

    exp_t gq [2][$];
    exp_t cq [2][$];
    exp_t rq [2][$];

    snake_dpb_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    snake_dpb_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

    snake_dpb_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    snake_dpb_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Write-first RAM models
    logic [DW-1:0] mem_a [2**AW];
    logic [DW-1:0] mem_b [2**AW];
    logic [DW-1:0] ra1, ra2, rb1;

    always @(posedge clk) begin
        if (a_if.b_clk_en) begin
            if (a_if.b_wr_en) begin
                mem_a[a_if.b_address] <= a_if.b_data;
                ra1 <= a_if.b_data;
            end else begin
                ra1 <= mem_a[a_if.b_address];
            end
        end
        ra2 <= ra1;
        if (b_if.b_clk_en) begin
            if (b_if.b_wr_en) begin
                mem_b[b_if.b_address] <= b_if.b_data;
                rb1 <= b_if.b_data;
            end else begin
                rb1 <= mem_b[b_if.b_address];
            end
        end
    end
    assign a_if.b_q = ra2;
    assign b_if.b_q = rb1;

    initial begin
        mem_a[11'h010] <= 8'h5A;
        mem_a[11'h020] <= 8'h11;
        mem_a[11'h021] <= 8'h22;
        mem_a[11'h100] <= 8'h00;
        mem_b[11'h055] <= 8'hC3;
        mem_b[11'h056] <= 8'h3C;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic miss(string name, int exp_cyc);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one at cycle %0d (now %0d)", name, exp_cyc, cycle);
    endtask

    task automatic unexp(string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event expected none (cycle %0d)", name, cycle);
    endtask

    // Push the expectations for one granted access in cycle t on side s
    task automatic push(int s, int t, logic owner, logic we, logic [AW-1:0] addr,
                        logic [DW-1:0] wdata, logic [DW-1:0] rdata, bit ret);
        exp_t e;
        e.owner = owner; e.we = we; e.addr = addr; e.data = wdata;
        e.cyc = t;                 gq[s].push_back(e);
        e.cyc = t + 1;             cq[s].push_back(e);
        if (ret) begin
            e.data = rdata;
            e.cyc  = t + 2 + lat[s];
            rq[s].push_back(e);
        end
    endtask

    task automatic mon(int s, logic g0, logic g1, logic rv0, logic rv1,
                       logic [DW-1:0] rd0, logic [DW-1:0] rd1, logic ce, logic we,
                       logic [AW-1:0] ad, logic [DW-1:0] dt);
        exp_t  e;
        string p;
        p = (s == 0) ? "lat2" : "lat1";
        while (gq[s].size() != 0 && gq[s][0].cyc < cycle) begin
            e = gq[s].pop_front(); miss({p, " gnt_missing"}, e.cyc);
        end
        while (cq[s].size() != 0 && cq[s][0].cyc < cycle) begin
            e = cq[s].pop_front(); miss({p, " cmd_missing"}, e.cyc);
        end
        while (rq[s].size() != 0 && rq[s][0].cyc < cycle) begin
            e = rq[s].pop_front(); miss({p, " rvalid_missing"}, e.cyc);
        end
        if (g0 || g1) begin
            chk({p, " gnt_exclusive"}, {31'b0, g0 & g1}, 32'd0);
            if (gq[s].size() == 0) unexp({p, " gnt_unexpected"});
            else begin
                e = gq[s].pop_front();
                chk({p, " gnt_owner"}, {31'b0, g1}, {31'b0, e.owner});
                chk({p, " gnt_cycle"}, cycle, e.cyc);
            end
        end
        if (ce === 1'b1) begin
            if (cq[s].size() == 0) unexp({p, " cmd_unexpected"});
            else begin
                e = cq[s].pop_front();
                chk({p, " cmd_we"},   {31'b0, we}, {31'b0, e.we});
                chk({p, " cmd_addr"}, {21'b0, ad}, {21'b0, e.addr});
                chk({p, " cmd_data"}, {24'b0, dt}, {24'b0, e.data});
                chk({p, " cmd_cycle"}, cycle, e.cyc);
            end
        end else begin
            chk({p, " idle_wr_en"}, {31'b0, we}, 32'd0);
        end
        if (rv0 || rv1) begin
            chk({p, " rvalid_exclusive"}, {31'b0, rv0 & rv1}, 32'd0);
            if (rq[s].size() == 0) unexp({p, " rvalid_unexpected"});
            else begin
                e = rq[s].pop_front();
                chk({p, " rd_owner"}, {31'b0, rv1}, {31'b0, e.owner});
                chk({p, " rd_data"}, {24'b0, rv1 ? rd1 : rd0}, {24'b0, e.data});
                chk({p, " rd_cycle"}, cycle, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_if.gnt0, a_if.gnt1, a_if.rvalid0, a_if.rvalid1, a_if.rdata0, a_if.rdata1,
            a_if.b_clk_en, a_if.b_wr_en, a_if.b_address, a_if.b_data);
        mon(1, b_if.gnt0, b_if.gnt1, b_if.rvalid0, b_if.rvalid1, b_if.rdata0, b_if.rdata1,
            b_if.b_clk_en, b_if.b_wr_en, b_if.b_address, b_if.b_data);
    end

    task automatic chk_reset_outs(string name);
        chk({name, " gnt0"},      {31'b0, a_if.gnt0},      32'd0);
        chk({name, " gnt1"},      {31'b0, a_if.gnt1},      32'd0);
        chk({name, " b_clk_en"},  {31'b0, a_if.b_clk_en},  32'd0);
        chk({name, " b_data_en"}, {31'b0, a_if.b_data_en}, 32'd0);
        chk({name, " b_wr_en"},   {31'b0, a_if.b_wr_en},   32'd0);
        chk({name, " b_address"}, {21'b0, a_if.b_address}, 32'd0);
        chk({name, " b_data"},    {24'b0, a_if.b_data},    32'd0);
        chk({name, " rvalid0"},   {31'b0, a_if.rvalid0},   32'd0);
        chk({name, " rvalid1"},   {31'b0, a_if.rvalid1},   32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of stimulus expected one by 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        {a_if.req0, a_if.req1, a_if.we0, a_if.we1} = '0;
        {b_if.req0, b_if.req1, b_if.we0, b_if.we1} = '0;
        a_if.addr0 = '0; a_if.addr1 = '0; a_if.wdata0 = '0; a_if.wdata1 = '0;
        b_if.addr0 = '0; b_if.addr1 = '0; b_if.wdata0 = '0; b_if.wdata1 = '0;

        // Reset with both reads held; requester 0 must win first
        rst = 1'b1;
        a_if.req0 = 1'b1; a_if.addr0 = 11'h020;
        a_if.req1 = 1'b1; a_if.addr1 = 11'h021;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        t = cycle;
        for (int i = 0; i < 6; i++) begin
            push(0, t + i, i[0], 1'b0, i[0] ? 11'h021 : 11'h020, 8'h00,
                 i[0] ? 8'h22 : 8'h11, 1'b1);
        end
        repeat (6) @(posedge clk);
        #1;
        a_if.req0 = 1'b0; a_if.req1 = 1'b0;
        chk("data_en_after_reset", {31'b0, a_if.b_data_en}, 32'd1);
        repeat (6) @(posedge clk);

        // Single read by requester 1
        #1;
        t = cycle;
        a_if.req1 = 1'b1; a_if.we1 = 1'b0; a_if.addr1 = 11'h010; a_if.wdata1 = 8'h00;
        push(0, t, 1'b1, 1'b0, 11'h010, 8'h00, 8'h5A, 1'b1);
        @(posedge clk); #1;
        a_if.req1 = 1'b0;
        repeat (6) @(posedge clk);

        // Read-after-write on the top address
        #1;
        t = cycle;
        a_if.req0 = 1'b1; a_if.we0 = 1'b1; a_if.addr0 = 11'h7FF; a_if.wdata0 = 8'h33;
        push(0, t, 1'b0, 1'b1, 11'h7FF, 8'h33, 8'h00, 1'b0);
        @(posedge clk); #1;
        a_if.we0 = 1'b0; a_if.wdata0 = 8'h00;
        push(0, t + 1, 1'b0, 1'b0, 11'h7FF, 8'h00, 8'h33, 1'b1);
        @(posedge clk); #1;
        a_if.req0 = 1'b0;
        repeat (6) @(posedge clk);

        // Write with no return, then read it back through the other requester
        #1;
        t = cycle;
        a_if.req1 = 1'b1; a_if.we1 = 1'b1; a_if.addr1 = 11'h100; a_if.wdata1 = 8'hA5;
        push(0, t, 1'b1, 1'b1, 11'h100, 8'hA5, 8'h00, 1'b0);
        @(posedge clk); #1;
        a_if.req1 = 1'b0; a_if.we1 = 1'b0; a_if.wdata1 = 8'h00;
        repeat (8) @(posedge clk);
        #1;
        t = cycle;
        a_if.req0 = 1'b1; a_if.addr0 = 11'h100;
        push(0, t, 1'b0, 1'b0, 11'h100, 8'h00, 8'hA5, 1'b1);
        @(posedge clk); #1;
        a_if.req0 = 1'b0;
        repeat (6) @(posedge clk);

        // Reset two cycles after a read grant: the read never returns
        #1;
        t = cycle;
        a_if.req0 = 1'b1; a_if.addr0 = 11'h010;
        push(0, t, 1'b0, 1'b0, 11'h010, 8'h00, 8'h5A, 1'b0);
        @(posedge clk); #1;
        a_if.req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        a_if.req0 = 1'b1; a_if.addr0 = 11'h020;
        a_if.req1 = 1'b1; a_if.addr1 = 11'h021;
        @(posedge clk); #1;
        chk_reset_outs("midflight_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        t = cycle;
        push(0, t,     1'b0, 1'b0, 11'h020, 8'h00, 8'h11, 1'b1);
        push(0, t + 1, 1'b1, 1'b0, 11'h021, 8'h00, 8'h22, 1'b1);
        repeat (2) @(posedge clk); #1;
        a_if.req0 = 1'b0; a_if.req1 = 1'b0;
        repeat (4) @(posedge clk);

        // RD_LAT=1 instance: two back-to-back single reads
        #1;
        t = cycle;
        b_if.req0 = 1'b1; b_if.addr0 = 11'h055;
        push(1, t, 1'b0, 1'b0, 11'h055, 8'h00, 8'hC3, 1'b1);
        @(posedge clk); #1;
        b_if.req0 = 1'b0;
        b_if.req1 = 1'b1; b_if.addr1 = 11'h056;
        push(1, t + 1, 1'b1, 1'b0, 11'h056, 8'h00, 8'h3C, 1'b1);
        @(posedge clk); #1;
        b_if.req1 = 1'b0;

        repeat (12) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("drain_gnt",    gq[s].size(), 32'd0);
            chk("drain_cmd",    cq[s].size(), 32'd0);
            chk("drain_rvalid", rq[s].size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_dpb_b_arbiter.md
# snake_dpb_b_arbiter

Round-robin arbiter sharing channel B of the snake-game dual-port block RAM between two requesters: the display scanner (requester 0) and the game logic (requester 1, collision/food checks). Channel A stays owned by the snake writer. The block serialises accesses into one channel-B command per cycle. It tracks in-flight reads through the RAM's pipelined output and returns each read to its owner with a valid strobe.

## Interface
Parameters:
- ADDR_W, 11, channel-B address width.
- DATA_W, 8, data width.
- RD_LAT, 2, RAM read latency in cycles from the command cycle to valid `b_q`. Legal values are 1 and 2.

Ports:
- clk  in  1  single clock for the block and the RAM.
- rst  in  1  reset: synchronous, active-high.
- req0 / req1  in  1  access request; held until granted.
- addr0 / addr1  in  ADDR_W  access address; stable while req is high.
- we0 / we1  in  1  1 = write, 0 = read.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational one-cycle accept pulse.
- rvalid0 / rvalid1  out  1  registered read-return strobe.
- rdata0 / rdata1  out  DATA_W  registered read data, valid with rvalid.
- b_clk_en  out  1  RAM ceb.
- b_data_en  out  1  RAM oceb.
- b_wr_en  out  1  RAM wreb.
- b_address  out  ADDR_W  RAM adb.
- b_data  out  DATA_W  RAM dinb.
- b_q  in  DATA_W  RAM doutb.

## Operation
- Arbitration:
  - `gnt_x = req_x & (~req_other | last != x)`.
  - `last` updates to the granted index on every grant.
  - Reset value of `last` is 1, so requester 0 wins the first contention.
  - With both requests held continuously, grants strictly alternate. No requester waits more than 1 cycle under contention.
- Issue register:
  - On a grant in cycle T, the block registers `b_clk_en=1`, `b_wr_en=we_x`, `b_address=addr_x`, `b_data=wdata_x`.
  - These drive the RAM in cycle T+1.
  - With no grant, `b_clk_en=0` and `b_wr_en=0`. Address and data hold their previous values.
- Tag pipeline:
  - A shift register of depth RD_LAT+1 carries {valid, owner} for each read issued.
  - Writes enter the pipeline as invalid.
  - When a tag reaches the output stage, `b_q` is registered into `rdata_owner` and `rvalid_owner` pulses for one cycle. The other requester's rdata holds its old value.
- `b_data_en` is 0 during reset and 1 otherwise.
- Throughput: one access per cycle, no bubbles, reads and writes mixed freely.
- Read-after-write to the same address via channel B returns the new data, because commands are issued in order and the RAM is in write-first mode.
- Reset:
  - All outputs are 0 and `last`=1.
  - The tag pipeline clears, so reads in flight at reset produce no rvalid.
  - A request held through reset is granted in the first cycle after `rst` falls.
- A requester that deasserts req without a grant is simply skipped; no error is flagged.

## Timing
- Grant: same cycle as the request when uncontended (combinational).
- Command on RAM pins: T+1 for a grant in cycle T.
- `b_q` valid: T+1+RD_LAT.
- rvalid/rdata: T+2+RD_LAT, which is 4 cycles after grant at the RD_LAT=2 default.
- rvalid pulses for back-to-back reads are contiguous and arrive in grant order.
- gnt0 and gnt1 are never high in the same cycle.

## Structure
- Shared package `snake_pkg`:
  - ADDR_W and DATA_W defaults.
  - Requester index constants REQ_DISP=0, REQ_GAME=1.
  - The FORWARD_* direction encodings (2'b00 X up, 2'b01 X down, 2'b10 Y up, 2'b11 Y down), so all snake blocks share them.
- One sub-module, `snake_rd_tag_pipe`: the parameterised {valid, owner} shift register with synchronous clear. The arbiter top holds only the grant logic and the issue and return registers.

## Test plan
- Single read: preload addr 0x010=0x5A, req1 read 0x010 in cycle 0 → gnt1 in cycle 0, b_address=0x010 with b_clk_en=1 in cycle 1, rvalid1=1 with rdata1=0x5A in cycle 4, rvalid0 stays 0.
- Contention: req0 and req1 both held as reads for 6 cycles starting after reset → grants go 0,1,0,1,0,1; rvalid pulses follow in the same order, 4 cycles later.
- Read-after-write: req0 writes 0x33 to 0x7FF, then req0 reads 0x7FF on the next cycle → rdata0=0x33; b_wr_en is high for exactly 1 cycle.
- Reset mid-flight: assert rst 2 cycles after a read grant → no rvalid is produced; all b_* outputs are 0 in the cycle after rst; first post-reset contention grants requester 0.
- Write with no return: req1 writes 0xA5 to 0x100 → rvalid1 stays 0 for 6 cycles.
- RD_LAT=1 build: single read → rvalid 3 cycles after grant with correct data.
